// File: rtl/circle_rasterizer.sv
// circle_rasterizer
//   Queues circle draw commands and raster-scans each clipped bounding box, one candidate
//   pixel per cycle, through a 3-stage squared-distance pipeline. Pixels inside the circle
//   leave on a valid/ready stream; candidates outside are dropped as bubbles.
//
// Ports
//   clk_in, rst_in                 clock, asynchronous active-high reset
//   cmd_valid_in / cmd_ready_out   command handshake (ready = queue not full)
//   cmd_hcount_in, cmd_vcount_in   circle centre
//   cmd_radius_in                  circle radius
//   cmd_thick_in                   ring thickness (RASTER_RING_EN only)
//   px_valid_out / px_ready_in     pixel stream handshake
//   px_hcount_out, px_vcount_out   pixel coordinates
//   done_out                       1-cycle pulse when a circle has fully drained
//   busy_out                       queue non-empty, scan active or pipeline occupied
//   circle_count_out               completed circles, wraps at 2^16
//
// Configuration
//   RASTER_RING_EN  adds cmd_thick_in; inside test becomes (r-t)^2 < d^2 <= r^2,
//                   with t >= r (t != 0) giving a filled disc.
module circle_rasterizer #(
    parameter int H_WIDTH    = 11,
    parameter int V_WIDTH    = 10,
    parameter int R_WIDTH    = 9,
    parameter int SCREEN_W   = 1280,
    parameter int SCREEN_H   = 720,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               cmd_valid_in,
    output logic               cmd_ready_out,
    input  logic [H_WIDTH-1:0] cmd_hcount_in,
    input  logic [V_WIDTH-1:0] cmd_vcount_in,
    input  logic [R_WIDTH-1:0] cmd_radius_in,
`ifdef RASTER_RING_EN
    input  logic [R_WIDTH-1:0] cmd_thick_in,
`endif
    output logic               px_valid_out,
    input  logic               px_ready_in,
    output logic [H_WIDTH-1:0] px_hcount_out,
    output logic [V_WIDTH-1:0] px_vcount_out,
    output logic               done_out,
    output logic               busy_out,
    output logic [15:0]        circle_count_out
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int XW  = H_WIDTH + 2;
    localparam int YW  = V_WIDTH + 2;
    localparam int DXW = R_WIDTH + 2;       // |delta| <= r always, so this is wide enough
    localparam int SW  = 2 * R_WIDTH + 2;
    localparam int DW  = SW + 1;

    localparam logic signed [XW-1:0] X_MAX = XW'(SCREEN_W - 1);
    localparam logic signed [YW-1:0] Y_MAX = YW'(SCREEN_H - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_SCAN  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    // ---------------------------------------------------------------- command queue
    logic [H_WIDTH-1:0] r_fifo_cx [FIFO_DEPTH];
    logic [V_WIDTH-1:0] r_fifo_cy [FIFO_DEPTH];
    logic [R_WIDTH-1:0] r_fifo_r  [FIFO_DEPTH];
`ifdef RASTER_RING_EN
    logic [R_WIDTH-1:0] r_fifo_t  [FIFO_DEPTH];
`endif
    logic [AW:0]        r_wptr;
    logic [AW:0]        r_rptr;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [1:0]         r_state;

    assign w_empty       = (r_wptr == r_rptr);
    assign w_full        = (r_wptr[AW] != r_rptr[AW]) &&
                           (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop         = (r_state == S_IDLE) && !w_empty;
    // A full queue still accepts when the head is leaving in the same cycle.
    assign cmd_ready_out = !w_full || w_pop;
    assign w_push        = cmd_valid_in && cmd_ready_out;

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_fifo_cx[r_wptr[AW-1:0]] <= cmd_hcount_in;
            r_fifo_cy[r_wptr[AW-1:0]] <= cmd_vcount_in;
            r_fifo_r[r_wptr[AW-1:0]]  <= cmd_radius_in;
`ifdef RASTER_RING_EN
            r_fifo_t[r_wptr[AW-1:0]]  <= cmd_thick_in;
`endif
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW + 1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (AW + 1)'(1);
        end
    end

    // ---------------------------------------------------------------- active command
    logic [H_WIDTH-1:0] r_cx;
    logic [V_WIDTH-1:0] r_cy;
    logic [R_WIDTH-1:0] r_r;
`ifdef RASTER_RING_EN
    logic [R_WIDTH-1:0] r_t;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cx <= '0;
            r_cy <= '0;
            r_r  <= '0;
`ifdef RASTER_RING_EN
            r_t  <= '0;
`endif
        end else if (w_pop) begin
            r_cx <= r_fifo_cx[r_rptr[AW-1:0]];
            r_cy <= r_fifo_cy[r_rptr[AW-1:0]];
            r_r  <= r_fifo_r[r_rptr[AW-1:0]];
`ifdef RASTER_RING_EN
            r_t  <= r_fifo_t[r_rptr[AW-1:0]];
`endif
        end
    end

    // ---------------------------------------------------------------- bounding box
    logic signed [XW-1:0] w_x_lo, w_x_hi, w_x_lo_c, w_x_hi_c;
    logic signed [YW-1:0] w_y_lo, w_y_hi, w_y_lo_c, w_y_hi_c;
    logic                 w_box_empty;

    assign w_x_lo   = $signed(XW'(r_cx)) - $signed(XW'(r_r));
    assign w_x_hi   = $signed(XW'(r_cx)) + $signed(XW'(r_r));
    assign w_y_lo   = $signed(YW'(r_cy)) - $signed(YW'(r_r));
    assign w_y_hi   = $signed(YW'(r_cy)) + $signed(YW'(r_r));
    assign w_x_lo_c = w_x_lo[XW-1] ? '0 : w_x_lo;
    assign w_y_lo_c = w_y_lo[YW-1] ? '0 : w_y_lo;
    assign w_x_hi_c = (w_x_hi > X_MAX) ? X_MAX : w_x_hi;
    assign w_y_hi_c = (w_y_hi > Y_MAX) ? Y_MAX : w_y_hi;
    // A centre far enough off-screen leaves lo above the clamped hi.
    assign w_box_empty = (w_x_lo_c > w_x_hi_c) || (w_y_lo_c > w_y_hi_c);

    // ---------------------------------------------------------------- FSM and scan
    logic [H_WIDTH-1:0] r_x0, r_x1, r_x;
    logic [V_WIDTH-1:0] r_y1, r_y;
    logic               r_done;
    logic [15:0]        r_count;
    logic               w_adv;
    logic               w_pipe_busy;
    logic               r_s1_v, r_s2_v, r_px_valid;

    assign w_adv       = !r_px_valid || px_ready_in;
    assign w_pipe_busy = r_s1_v || r_s2_v || r_px_valid;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
            r_x0    <= '0;
            r_x1    <= '0;
            r_y1    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) r_state <= S_SETUP;
                end
                S_SETUP: begin
                    r_x0    <= w_x_lo_c[H_WIDTH-1:0];
                    r_x1    <= w_x_hi_c[H_WIDTH-1:0];
                    r_y1    <= w_y_hi_c[V_WIDTH-1:0];
                    r_x     <= w_x_lo_c[H_WIDTH-1:0];
                    r_y     <= w_y_lo_c[V_WIDTH-1:0];
                    r_state <= w_box_empty ? S_DRAIN : S_SCAN;
                end
                S_SCAN: begin
                    if (w_adv) begin
                        if (r_x == r_x1) begin
                            if (r_y == r_y1) begin
                                r_state <= S_DRAIN;
                            end else begin
                                r_x <= r_x0;
                                r_y <= r_y + V_WIDTH'(1);
                            end
                        end else begin
                            r_x <= r_x + H_WIDTH'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (!w_pipe_busy) begin
                        r_done  <= 1'b1;
                        r_count <= r_count + 16'd1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- distance pipeline
    logic [DXW-1:0]     w_dx, w_dy, w_adx, w_ady;
    logic [H_WIDTH-1:0] r_s1_x, r_s2_x, r_px_x;
    logic [V_WIDTH-1:0] r_s1_y, r_s2_y, r_px_y;
    logic [DXW-1:0]     r_s1_adx, r_s1_ady;
    logic [SW-1:0]      r_s2_dx2, r_s2_dy2, r_s2_r2;
`ifdef RASTER_RING_EN
    logic [SW-1:0]      r_s2_in2;
    logic               r_s2_filled;
`endif
    logic [DW-1:0]      w_d2;
    logic               w_inside;

    // Differences wrap modulo 2^DXW; the true value lies in [-r, r] so no information is lost.
    assign w_dx  = DXW'(r_x) - DXW'(r_cx);
    assign w_dy  = DXW'(r_y) - DXW'(r_cy);
    assign w_adx = w_dx[DXW-1] ? -w_dx : w_dx;
    assign w_ady = w_dy[DXW-1] ? -w_dy : w_dy;

    assign w_d2 = DW'(r_s2_dx2) + DW'(r_s2_dy2);
`ifdef RASTER_RING_EN
    assign w_inside = (w_d2 <= DW'(r_s2_r2)) && (r_s2_filled || (w_d2 > DW'(r_s2_in2)));
`else
    assign w_inside = (w_d2 <= DW'(r_s2_r2));
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_s1_v      <= 1'b0;
            r_s1_x      <= '0;
            r_s1_y      <= '0;
            r_s1_adx    <= '0;
            r_s1_ady    <= '0;
            r_s2_v      <= 1'b0;
            r_s2_x      <= '0;
            r_s2_y      <= '0;
            r_s2_dx2    <= '0;
            r_s2_dy2    <= '0;
            r_s2_r2     <= '0;
`ifdef RASTER_RING_EN
            r_s2_in2    <= '0;
            r_s2_filled <= 1'b0;
`endif
            r_px_valid  <= 1'b0;
            r_px_x      <= '0;
            r_px_y      <= '0;
        end else if (w_adv) begin
            // S1: candidate from the scan position
            r_s1_v      <= (r_state == S_SCAN);
            r_s1_x      <= r_x;
            r_s1_y      <= r_y;
            r_s1_adx    <= w_adx;
            r_s1_ady    <= w_ady;
            // S2: squares
            r_s2_v      <= r_s1_v;
            r_s2_x      <= r_s1_x;
            r_s2_y      <= r_s1_y;
            r_s2_dx2    <= SW'(r_s1_adx) * SW'(r_s1_adx);
            r_s2_dy2    <= SW'(r_s1_ady) * SW'(r_s1_ady);
            r_s2_r2     <= SW'(r_r) * SW'(r_r);
`ifdef RASTER_RING_EN
            r_s2_in2    <= SW'(r_r - r_t) * SW'(r_r - r_t);
            r_s2_filled <= (r_t >= r_r) && (r_t != '0);
`endif
            // S3: inside test feeds the output register; misses become bubbles
            r_px_valid  <= r_s2_v && w_inside;
            r_px_x      <= r_s2_x;
            r_px_y      <= r_s2_y;
        end
    end

    assign px_valid_out     = r_px_valid;
    assign px_hcount_out    = r_px_x;
    assign px_vcount_out    = r_px_y;
    assign done_out         = r_done;
    assign circle_count_out = r_count;
    assign busy_out         = !w_empty || (r_state != S_IDLE) || w_pipe_busy;

endmodule

// File: tb/tb_circle_rasterizer.sv
module tb_circle_rasterizer;

    localparam int HW = 11;
    localparam int VW = 10;
    localparam int RW = 9;

    typedef logic [HW+VW-1:0] pix_t;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          cmd_valid_in = 1'b0;
    logic          cmd_ready_out;
    logic [HW-1:0] cmd_hcount_in = '0;
    logic [VW-1:0] cmd_vcount_in = '0;
    logic [RW-1:0] cmd_radius_in = '0;
`ifdef RASTER_RING_EN
    logic [RW-1:0] cmd_thick_in = '0;
`endif
    logic          px_valid_out;
    logic          px_ready_in = 1'b0;
    logic [HW-1:0] px_hcount_out;
    logic [VW-1:0] px_vcount_out;
    logic          done_out;
    logic          busy_out;
    logic [15:0]   circle_count_out;

    int   n_vec = 0;
    int   n_err = 0;
    int   exp_done = 0;
    pix_t exp_q[$];

    always #5 clk_in = ~clk_in;

    circle_rasterizer dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .cmd_valid_in     (cmd_valid_in),
        .cmd_ready_out    (cmd_ready_out),
        .cmd_hcount_in    (cmd_hcount_in),
        .cmd_vcount_in    (cmd_vcount_in),
        .cmd_radius_in    (cmd_radius_in),
`ifdef RASTER_RING_EN
        .cmd_thick_in     (cmd_thick_in),
`endif
        .px_valid_out     (px_valid_out),
        .px_ready_in      (px_ready_in),
        .px_hcount_out    (px_hcount_out),
        .px_vcount_out    (px_vcount_out),
        .done_out         (done_out),
        .busy_out         (busy_out),
        .circle_count_out (circle_count_out)
    );

    // Reference: row-major scan of the box, clipped to screen. t < 0 or (t >= r, t != 0)
    // means a filled disc; otherwise the ring (r-t)^2 < d^2 <= r^2.
    task automatic model_circle(input int cx, input int cy, input int r, input int t);
        for (int y = cy - r; y <= cy + r; y++) begin
            for (int x = cx - r; x <= cx + r; x++) begin
                int   d2;
                bit   hit;
                pix_t p;
                d2  = (x - cx) * (x - cx) + (y - cy) * (y - cy);
                hit = (d2 <= r * r) && (x >= 0) && (x < 1280) && (y >= 0) && (y < 720);
                if (t >= 0 && !(t >= r && t != 0)) hit = hit && (d2 > (r - t) * (r - t));
                if (hit) begin
                    p = {x[HW-1:0], y[VW-1:0]};
                    exp_q.push_back(p);
                end
            end
        end
    endtask

    // Issue one command and record its expected pixels and completion.
    task automatic push_cmd(input int cx, input int cy, input int r, input int t);
        int waited = 0;
        px_ready_in   = 1'b0;
        cmd_valid_in  = 1'b1;
        cmd_hcount_in = cx[HW-1:0];
        cmd_vcount_in = cy[VW-1:0];
        cmd_radius_in = r[RW-1:0];
`ifdef RASTER_RING_EN
        cmd_thick_in  = t[RW-1:0];
`endif
        @(negedge clk_in);
        while (!cmd_ready_out && waited < 50) begin
            @(negedge clk_in);
            waited++;
        end
        n_vec++;
        if (!cmd_ready_out) begin
            n_err++;
            $display("FAIL push_ready: cmd_ready_out stayed %0b, wanted 1", cmd_ready_out);
        end else begin
            model_circle(cx, cy, r, t);
            exp_done++;
        end
        @(posedge clk_in);
        #1;
        cmd_valid_in = 1'b0;
    endtask

    // One clock: drive ready, sample outputs on the falling edge, return after the next rise.
    task automatic step(input logic rdy, output logic vld, output logic xfer,
                        output pix_t pix, output logic dn);
        px_ready_in = rdy;
        @(negedge clk_in);
        vld  = px_valid_out;
        xfer = px_valid_out && px_ready_in;
        pix  = {px_hcount_out, px_vcount_out};
        dn   = done_out;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        n_vec++;
        if (cmd_ready_out !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready_in_reset: got %0b want 1", cmd_ready_out);
        end
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        n_vec++;
        if (px_valid_out !== 1'b0) begin
            n_err++; $display("FAIL reset_px_valid: got %0b want 0", px_valid_out);
        end
        n_vec++;
        if (done_out !== 1'b0 || busy_out !== 1'b0) begin
            n_err++; $display("FAIL reset_done_busy: got %0b/%0b want 0/0", done_out, busy_out);
        end
        n_vec++;
        if (circle_count_out !== 16'd0) begin
            n_err++; $display("FAIL reset_count: got %0d want 0", circle_count_out);
        end
        n_vec++;
        if ({px_hcount_out, px_vcount_out} !== '0) begin
            n_err++; $display("FAIL reset_px_coord: got (%0d,%0d) want (0,0)",
                              px_hcount_out, px_vcount_out);
        end
    endtask

    task automatic test_radius0();
        logic vld, xfer, dn;
        pix_t pix, want;
        int   got = 0, first = -1, dones = 0;
        push_cmd(100, 100, 0, 511);
        for (int c = 0; c < 40 && dones == 0; c++) begin
            step(1'b1, vld, xfer, pix, dn);
            if (xfer) begin
                got++;
                if (first < 0) first = c;
                n_vec++;
                want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                if (pix !== want) begin
                    n_err++; $display("FAIL r0_pixel: got %h want %h", pix, want);
                end
            end
            if (dn) dones++;
        end
        n_vec++;
        if (first != 5) begin
            n_err++; $display("FAIL r0_latency: first pixel at cycle %0d want 5", first);
        end
        n_vec++;
        if (got != 1 || dones != 1) begin
            n_err++; $display("FAIL r0_counts: got %0d pixels %0d dones want 1 1", got, dones);
        end
        n_vec++;
        if (circle_count_out !== 16'(exp_done)) begin
            n_err++; $display("FAIL r0_circle_count: got %0d want %0d", circle_count_out, exp_done);
        end
    endtask

    // Runs the queued commands to completion with always-ready or random backpressure.
    task automatic test_stream(input string name, input bit random_ready, input int n_done,
                               input int n_pix);
        logic vld, xfer, dn, rdy;
        logic hold = 1'b0;
        pix_t pix, want, held;
        int   got = 0, dones = 0;
        for (int c = 0; c < 600 && dones < n_done; c++) begin
            rdy = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step(rdy, vld, xfer, pix, dn);
            if (hold) begin
                n_vec++;
                if (vld !== 1'b1 || pix !== held) begin
                    n_err++;
                    $display("FAIL %s_stall_hold: got v=%0b %h want v=1 %h", name, vld, pix, held);
                end
            end
            hold = vld && !rdy;
            held = pix;
            if (xfer) begin
                got++;
                n_vec++;
                want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                if (pix !== want) begin
                    n_err++; $display("FAIL %s_pixel: #%0d got %h want %h", name, got, pix, want);
                end
            end
            if (dn) dones++;
        end
        n_vec++;
        if (got != n_pix || dones != n_done || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_totals: got %0d pixels %0d dones (%0d left), want %0d %0d",
                     name, got, dones, exp_q.size(), n_pix, n_done);
        end
        n_vec++;
        if (circle_count_out !== 16'(exp_done)) begin
            n_err++; $display("FAIL %s_circle_count: got %0d want %0d", name,
                              circle_count_out, exp_done);
        end
    endtask

    task automatic test_filled();
        push_cmd(10, 10, 2, 511);
        test_stream("r2", 1'b0, 1, 13);
    endtask

    task automatic test_clip();
        push_cmd(0, 0, 2, 511);
        test_stream("corner", 1'b0, 1, 6);
        push_cmd(2000, 900, 5, 511);
        test_stream("offscreen", 1'b0, 1, 0);
    endtask

    task automatic test_backpressure();
        push_cmd(10, 10, 2, 511);
        test_stream("stall", 1'b1, 1, 13);
    endtask

    task automatic test_back_to_back();
        push_cmd(50, 50, 1, 511);
        push_cmd(52, 50, 1, 511);
        push_cmd(60, 60, 3, 511);
        test_stream("b2b", 1'b1, 3, 39);
    endtask

    task automatic test_full_reset();
        logic rdy_seen = 1'b1;
        logic vld, xfer, dn;
        logic saw_px = 1'b0, saw_dn = 1'b0;
        pix_t pix;
        int   acc = 0;
        px_ready_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmd_valid_in  = 1'b1;
            cmd_hcount_in = HW'(200 + i * 20);
            cmd_vcount_in = VW'(200);
            cmd_radius_in = RW'(3);
            @(negedge clk_in);
            rdy_seen = cmd_ready_out;
            if (rdy_seen) acc++;
            @(posedge clk_in);
            #1;
        end
        cmd_valid_in = 1'b0;
        n_vec++;
        if (rdy_seen !== 1'b0 || acc != 5) begin
            n_err++; $display("FAIL full_ready: last ready %0b accepted %0d want 0 5",
                              rdy_seen, acc);
        end
        repeat (4) @(posedge clk_in);
        #1;
        n_vec++;
        if (busy_out !== 1'b1 || px_valid_out !== 1'b1) begin
            n_err++; $display("FAIL full_stalled: busy %0b valid %0b want 1 1",
                              busy_out, px_valid_out);
        end
        rst_in = 1'b1;
        #1;
        n_vec++;
        if (px_valid_out !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0 ||
            circle_count_out !== 16'd0 || cmd_ready_out !== 1'b1) begin
            n_err++;
            $display("FAIL midscan_reset: v%0b b%0b d%0b cnt%0d rdy%0b want v0 b0 d0 cnt0 rdy1",
                     px_valid_out, busy_out, done_out, circle_count_out, cmd_ready_out);
        end
        exp_q.delete();
        exp_done = 0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step(1'b1, vld, xfer, pix, dn);
            saw_px |= vld;
            saw_dn |= dn;
        end
        n_vec++;
        if (saw_px || saw_dn || busy_out !== 1'b0) begin
            n_err++; $display("FAIL post_reset_quiet: pixel %0b done %0b busy %0b want 0 0 0",
                              saw_px, saw_dn, busy_out);
        end
    endtask

`ifdef RASTER_RING_EN
    task automatic test_ring();
        push_cmd(10, 10, 2, 1);
        test_stream("ring_t1", 1'b0, 1, 8);
        push_cmd(10, 10, 2, 0);
        test_stream("ring_t0", 1'b0, 1, 0);
    endtask
`endif

    initial begin
        repeat (2) @(posedge clk_in);
        #1;
        test_reset();
        test_radius0();
        test_filled();
        test_clip();
        test_backpressure();
        test_back_to_back();
        test_full_reset();
`ifdef RASTER_RING_EN
        test_ring();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
